// File: rtl/mem_responder.sv
// mem_responder: word-wide memory responder for the core's data/instruction bus.
// Stores 32-bit bus words verbatim (byte at address+0 on bits [31:24], no swapping)
// and answers each request LATENCY cycles after acceptance, holding mem_stall
// high while the request is in flight. LATENCY=0 gives a combinational read.
// Optional feature: define MEM_RESP_BOUNDS_EN to add mem_err and treat
// addresses with bits above the word index set as out of range.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_cen,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall
`ifdef MEM_RESP_BOUNDS_EN
  ,
  output logic        mem_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // Word storage; deliberately not reset so it maps onto block RAM.
  logic [31:0] mem_array [DEPTH];

  logic [ADDR_W-1:0] req_index;
  logic              req_oor;

  assign req_index = mem_addr[ADDR_W+1:2];

`ifdef MEM_RESP_BOUNDS_EN
  assign req_oor = |mem_addr[31:ADDR_W+2];
`else
  // Upper address bits simply alias onto the array.
  assign req_oor = 1'b0;
`endif

  // Byte-offset bits (and, without bounds checking, the upper bits) carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[1:0], mem_addr[31:ADDR_W+2]};

  if (LATENCY == 0) begin : g_comb

    // Write lands on the edge where the request is presented; reset blocks it.
    always_ff @(posedge clk) begin
      if (rst_n && mem_cen && mem_wen && !req_oor) begin
        mem_array[req_index] <= mem_wdata;
      end
    end

    assign mem_rdata = (!rst_n || req_oor) ? 32'h0 : mem_array[req_index];
    assign mem_stall = 1'b0;

`ifdef MEM_RESP_BOUNDS_EN
    assign mem_err = rst_n & mem_cen & req_oor;
`endif

  end else begin : g_fsm

    typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] idx_reg;
    logic              wen_reg;
    logic [31:0]       wdata_reg;
    logic              oor_reg;
    logic [31:0]       rdata_reg;

    // "fire" marks the edge that completes a request: commit a write or load read data.
    logic              accept;
    logic              fire;
    logic              fire_wen;
    logic [ADDR_W-1:0] fire_idx;
    logic [31:0]       fire_wdata;
    logic              fire_oor;

    // Next-state, stall and completion decode; LATENCY=1 completes straight from IDLE on live inputs.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mem_stall  = 1'b0;
      accept     = 1'b0;
      fire       = 1'b0;
      fire_wen   = wen_reg;
      fire_idx   = idx_reg;
      fire_wdata = wdata_reg;
      fire_oor   = oor_reg;
      case (state_reg)
        IDLE: begin
          mem_stall = mem_cen;
          if (mem_cen) begin
            accept   = 1'b1;
            cnt_next = 4'(LATENCY - 1);
            if (LATENCY > 1) begin
              state_next = WAIT;
            end else begin
              state_next = DONE;
              fire       = 1'b1;
              fire_wen   = mem_wen;
              fire_idx   = req_index;
              fire_wdata = mem_wdata;
              fire_oor   = req_oor;
            end
          end
        end
        WAIT: begin
          mem_stall = 1'b1;
          cnt_next  = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_next = DONE;
            fire       = 1'b1;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // FSM state, latched request and read-data register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= IDLE;
        cnt_reg   <= 4'd0;
        idx_reg   <= '0;
        wen_reg   <= 1'b0;
        wdata_reg <= 32'h0;
        oor_reg   <= 1'b0;
        rdata_reg <= 32'h0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        if (accept) begin
          idx_reg   <= req_index;
          wen_reg   <= mem_wen;
          wdata_reg <= mem_wdata;
          oor_reg   <= req_oor;
        end
        if (fire && !fire_wen) begin
          rdata_reg <= fire_oor ? 32'h0 : mem_array[fire_idx];
        end
      end
    end

    // Write commit on the completing edge; gated by rst_n so reset never commits.
    always_ff @(posedge clk) begin
      if (rst_n && fire && fire_wen && !fire_oor) begin
        mem_array[fire_idx] <= fire_wdata;
      end
    end

    assign mem_rdata = rdata_reg;

`ifdef MEM_RESP_BOUNDS_EN
    logic err_reg;

    // Error flag is high only during the DONE cycle of an out-of-range request.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_reg <= 1'b0;
      end else begin
        err_reg <= fire & fire_oor;
      end
    end

    assign mem_err = err_reg;
`endif

  end

endmodule
